// File: rtl/rx_jesd204b_cgs_align.sv
// rx_jesd204b_cgs_align
// JESD204B RX code-group synchronisation: comma search over a 20-bit window,
// CS_INIT / CS_CHECK / CS_DATA state machine, SYNC~ generation, and
// registered word-aligned symbols (abcdeifghj, bit 9 = a) for the decoder.
//
// Optional build macro CGS_RD_CHECK_EN: adds running-disparity tracking in
// CS_CHECK / CS_DATA, folds disparity errors into sym_inv, exports rd_out.
//
// Handshake: din is consumed only on cycles with din_valid = 1 (no
// back-pressure); sym_valid is din_valid delayed by one cycle, and
// sym_out / sym_is_k / sym_inv are meaningful only while sym_valid = 1.
module rx_jesd204b_cgs_align #(
    parameter int KCNT_LOCK = 4,
    parameter int INV_LOSS  = 3,
    parameter int VALID_RUN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       din_valid,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       sym_is_k,
    output logic       sym_inv,
    output logic       sync_n,
    output logic [1:0] cgs_state,
`ifdef CGS_RD_CHECK_EN
    output logic       rd_out,
`endif
    output logic [3:0] align_offset,
    output logic       loss_pulse
);

    typedef enum logic [1:0] {
        CS_INIT  = 2'd0,
        CS_CHECK = 2'd1,
        CS_DATA  = 2'd2
    } cgs_t;

    cgs_t       state;
    logic [9:0] prev_word;
    logic [3:0] kcnt;
    logic [3:0] icnt;
    logic [3:0] vrun;

    logic [19:0] win;
    logic [9:0]  cur;
    logic        cur_k;
    logic        cur_inv;
    logic        comma_found;
    logic [3:0]  comma_k;
    logic        comma_is_k;
    logic [3:0]  kcnt_next;
    logic [3:0]  icnt_inc;
    logic [3:0]  icnt_dec;
    logic [3:0]  vrun_inc;

    // Candidate symbol starting k bits into the window (k = 0 is prev_word).
    function automatic logic [9:0] cand_at(input logic [19:0] w, input logic [3:0] k);
        logic [19:0] t;
        t = w >> (5'd10 - {1'b0, k});
        return t[9:0];
    endfunction

    function automatic logic is_k285(input logic [9:0] s);
        return (s == 10'h0FA) || (s == 10'h305);
    endfunction

    // Code-space check: ones count 4..6 and no all-equal sub-block.
    function automatic logic code_bad(input logic [9:0] s);
        int ones;
        ones = $countones(s);
        return (ones < 4) || (ones > 6) ||
               (s[9:4] == 6'h00) || (s[9:4] == 6'h3F) ||
               (s[3:0] == 4'h0)  || (s[3:0] == 4'hF);
    endfunction

    assign win       = {prev_word, din};
    assign cur       = cand_at(win, align_offset);
    assign cur_k     = is_k285(cur);
    assign cgs_state = state;

`ifdef CGS_RD_CHECK_EN
    logic rd;
    logic rd_conflict;
    logic rd_after;

    // Disparity of each sub-block against the running disparity entering it.
    always_comb begin
        int o6;
        int o4;
        logic r;
        rd_conflict = 1'b0;
        r  = rd;
        o6 = $countones(cur[9:4]);
        o4 = $countones(cur[3:0]);
        if (o6 > 3 || cur[9:4] == 6'b000111) begin
            if (r) rd_conflict = 1'b1;
            r = 1'b1;
        end else if (o6 < 3 || cur[9:4] == 6'b111000) begin
            if (!r) rd_conflict = 1'b1;
            r = 1'b0;
        end
        if (o4 > 2 || cur[3:0] == 4'b0011) begin
            if (r) rd_conflict = 1'b1;
            r = 1'b1;
        end else if (o4 < 2 || cur[3:0] == 4'b1100) begin
            if (!r) rd_conflict = 1'b1;
            r = 1'b0;
        end
        rd_after = r;
    end

    assign cur_inv = code_bad(cur) || ((state != CS_INIT) && rd_conflict);
    assign rd_out  = rd;

    // Running disparity: seeded by the locking K28.5, tracked once locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= 1'b0;
        end else if (din_valid) begin
            if (state == CS_INIT) begin
                if (kcnt_next >= 4'(KCNT_LOCK)) rd <= (cur == 10'h0FA);
            end else begin
                rd <= rd_after;
            end
        end
    end
`else
    assign cur_inv = code_bad(cur);
`endif

    // Comma search across all ten offsets; the lowest offset wins.
    always_comb begin
        comma_found = 1'b0;
        comma_k     = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (win[19-k -: 7] == 7'b0011111 || win[19-k -: 7] == 7'b1100000) begin
                comma_found = 1'b1;
                comma_k     = 4'(k);
            end
        end
        comma_is_k = is_k285(cand_at(win, comma_k));
    end

    // Saturating counter arithmetic and the CS_INIT K28.5 count update.
    always_comb begin
        icnt_inc = (icnt == 4'hF) ? icnt : icnt + 4'd1;
        icnt_dec = (icnt == 4'h0) ? icnt : icnt - 4'd1;
        vrun_inc = (vrun == 4'hF) ? vrun : vrun + 4'd1;
        if (comma_found && comma_k != align_offset) begin
            kcnt_next = comma_is_k ? 4'd1 : 4'd0;
        end else if (cur_k) begin
            kcnt_next = (kcnt == 4'hF) ? kcnt : kcnt + 4'd1;
        end else begin
            kcnt_next = 4'd0;
        end
    end

    // Synchronisation FSM with registered symbol outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CS_INIT;
            prev_word    <= 10'd0;
            kcnt         <= 4'd0;
            icnt         <= 4'd0;
            vrun         <= 4'd0;
            align_offset <= 4'd0;
            sync_n       <= 1'b0;
            sym_out      <= 10'd0;
            sym_valid    <= 1'b0;
            sym_is_k     <= 1'b0;
            sym_inv      <= 1'b0;
            loss_pulse   <= 1'b0;
        end else begin
            loss_pulse <= 1'b0;
            sym_valid  <= din_valid;
            if (din_valid) begin
                prev_word <= din;
                sym_out   <= cur;
                sym_is_k  <= cur_k;
                sym_inv   <= cur_inv;
                case (state)
                    CS_INIT: begin
                        kcnt <= kcnt_next;
                        if (comma_found && comma_k != align_offset) begin
                            align_offset <= comma_k;
                        end
                        if (kcnt_next >= 4'(KCNT_LOCK)) begin
                            state  <= CS_DATA;
                            sync_n <= 1'b1;
                            kcnt   <= 4'd0;
                        end
                    end
                    CS_DATA: begin
                        if (cur_inv) begin
                            state <= CS_CHECK;
                            icnt  <= 4'd1;
                            vrun  <= 4'd0;
                        end
                    end
                    CS_CHECK: begin
                        if (cur_inv) begin
                            icnt <= icnt_inc;
                            vrun <= 4'd0;
                            if (icnt_inc >= 4'(INV_LOSS)) begin
                                state      <= CS_INIT;
                                sync_n     <= 1'b0;
                                loss_pulse <= 1'b1;
                                kcnt       <= 4'd0;
                            end
                        end else if (vrun_inc >= 4'(VALID_RUN)) begin
                            vrun <= 4'd0;
                            icnt <= icnt_dec;
                            if (icnt_dec == 4'd0) state <= CS_DATA;
                        end else begin
                            vrun <= vrun_inc;
                        end
                    end
                    default: state <= CS_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_jesd204b_cgs_align.sv
// Self-checking bench for rx_jesd204b_cgs_align: bit-stream driven stimulus
// with random phase and din_valid gaps against a symbol-level model.
module tb_rx_jesd204b_cgs_align;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       din_valid;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       sym_is_k;
  logic       sym_inv;
  logic       sync_n;
  logic [1:0] cgs_state;
  logic [3:0] align_offset;
  logic       loss_pulse;
`ifdef CGS_RD_CHECK_EN
  logic       rd_out;
`endif

  // clock / reset
  always #5 clk = ~clk;

  rx_jesd204b_cgs_align dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .sym_is_k     (sym_is_k),
    .sym_inv      (sym_inv),
    .sync_n       (sync_n),
    .cgs_state    (cgs_state),
`ifdef CGS_RD_CHECK_EN
    .rd_out       (rd_out),
`endif
    .align_offset (align_offset),
    .loss_pulse   (loss_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;
  int loss_seen = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: symbol-level view of the synchroniser
  logic [9:0] m_prev;
  int         m_off, m_state, m_k, m_i, m_v;
  logic [9:0] m_so;
  logic       m_sv, m_isk, m_inv, m_sync, m_loss;

  function automatic logic [9:0] sym_at(input logic [19:0] w, input int k);
    logic [9:0] s;
    for (int i = 0; i < 10; i++) s[9-i] = w[19-k-i];
    return s;
  endfunction

  function automatic logic bad_sym(input logic [9:0] s);
    int ones;
    ones = 0;
    for (int i = 0; i < 10; i++) ones += int'(s[i]);
    return (ones < 4) || (ones > 6) || (s[9:4] == 6'h00) || (s[9:4] == 6'h3F) ||
           (s[3:0] == 4'h0) || (s[3:0] == 4'hF);
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [9:0] d);
    logic [19:0] w;
    logic [9:0]  c;
    logic [9:0]  p;
    int          first;
    if (r) begin
      m_prev = 0; m_off = 0; m_state = 0; m_k = 0; m_i = 0; m_v = 0;
      m_so = 0; m_sv = 0; m_isk = 0; m_inv = 0; m_sync = 0; m_loss = 0;
    end else begin
      m_loss = 0;
      m_sv   = v;
      if (v) begin
        w = {m_prev, d};
        c = sym_at(w, m_off);
        first = -1;
        for (int k = 0; k < 10; k++) begin
          p = sym_at(w, k);
          if (first < 0 && (p[9:3] == 7'b0011111 || p[9:3] == 7'b1100000)) first = k;
        end
        m_so  = c;
        m_isk = (c == 10'h0FA) || (c == 10'h305);
        m_inv = bad_sym(c);
        if (m_state == 0) begin
          if (first >= 0 && first != m_off) begin
            m_off = first;
            p = sym_at(w, first);
            m_k = (p == 10'h0FA || p == 10'h305) ? 1 : 0;
          end else if (m_isk) begin
            m_k++;
          end else begin
            m_k = 0;
          end
          if (m_k >= 4) begin m_state = 2; m_sync = 1; m_k = 0; end
        end else if (m_state == 2) begin
          if (m_inv) begin m_state = 1; m_i = 1; m_v = 0; end
        end else begin
          if (m_inv) begin
            m_i++; m_v = 0;
            if (m_i >= 3) begin m_state = 0; m_sync = 0; m_loss = 1; m_k = 0; end
          end else begin
            m_v++;
            if (m_v >= 4) begin
              m_v = 0; m_i--;
              if (m_i == 0) m_state = 2;
            end
          end
        end
        m_prev = d;
      end
    end
  endtask

  // driver: one clock with given inputs, then compare every output
  task automatic step(input logic r, input logic v, input logic [9:0] d);
    rst = r; din_valid = v; din = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    if (loss_pulse === 1'b1) loss_seen++;
    check("sym_valid", 16'(sym_valid), 16'(m_sv));
    if (m_sv || r) begin
      check("sym_out", 16'(sym_out), 16'(m_so));
      check("sym_is_k", 16'(sym_is_k), 16'(m_isk));
      check("sym_inv", 16'(sym_inv), 16'(m_inv));
    end
    check("sync_n", 16'(sync_n), 16'(m_sync));
    check("cgs_state", 16'(cgs_state), 16'(m_state));
    check("align_offset", 16'(align_offset), 16'(m_off));
    check("loss_pulse", 16'(loss_pulse), 16'(m_loss));
  endtask

  // bit-level serial stream, cut into 10-bit words
  bit bq[$];
  bit k_rdp = 1'b0;

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
  endtask

  task automatic push_bits(input int n);
    for (int i = 0; i < n; i++) bq.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic send_k(input int n);
    for (int i = 0; i < n; i++) begin
      push_sym(k_rdp ? 10'h305 : 10'h0FA);
      k_rdp = ~k_rdp;
    end
  endtask

  task automatic flush_words();
    logic [9:0] w;
    while (bq.size() >= 10) begin
      for (int i = 0; i < 10; i++) w[9-i] = bq.pop_front();
      step(1'b0, 1'b1, w);
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 10'($urandom));
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'($urandom_range(0, 1)), 10'($urandom));
    step(1'b1, 1'b0, 10'($urandom));
    bq.delete();
    k_rdp = 1'b0;
  endtask

  logic [9:0] pick_tab [6];

  initial begin
    pick_tab[0] = 10'h0FA; pick_tab[1] = 10'h305; pick_tab[2] = 10'h2AA;
    pick_tab[3] = 10'h155; pick_tab[4] = 10'h000; pick_tab[5] = 10'h3FF;
    rst = 1'b1; din_valid = 1'b0; din = 10'd0;

    // reset state
    do_reset();
    check("rst_sym_valid", 16'(sym_valid), 16'd0);
    check("rst_sync_n", 16'(sync_n), 16'd0);
    check("rst_state", 16'(cgs_state), 16'd0);
    check("rst_offset", 16'(align_offset), 16'd0);

    // aligned K28.5 stream locks at offset 0
    send_k(8);
    flush_words();
    check("t1_state", 16'(cgs_state), 16'd2);
    check("t1_sync", 16'(sync_n), 16'd1);
    check("t1_offset", 16'(align_offset), 16'd0);

    // three invalids separated by valids force loss, then relock
    loss_seen = 0;
    push_sym(10'h000); push_sym(10'h2AA); push_sym(10'h000);
    push_sym(10'h2AA); push_sym(10'h000); push_sym(10'h2AA);
    flush_words();
    check("t3_state", 16'(cgs_state), 16'd0);
    check("t3_sync", 16'(sync_n), 16'd0);
    check("t3_loss_count", 16'(loss_seen), 16'd1);
    send_k(8);
    flush_words();
    check("t3_relock", 16'(cgs_state), 16'd2);

    // stream delayed by 3 bits
    do_reset();
    push_bits(3);
    send_k(8);
    push_sym(10'h2AA);
    flush_words();
    check("t2_offset", 16'(align_offset), 16'd3);
    check("t2_state", 16'(cgs_state), 16'd2);

    // single invalid followed by a valid run recovers without loss
    loss_seen = 0;
    push_sym(10'h3FF);
    for (int i = 0; i < 5; i++) push_sym(10'h2AA);
    flush_words();
    check("t4_state", 16'(cgs_state), 16'd2);
    check("t4_no_loss", 16'(loss_seen), 16'd0);

    // interrupted K run restarts the count
    do_reset();
    send_k(3);
    push_sym(10'h2AA);
    send_k(4);
    push_sym(10'h2AA);
    flush_words();
    check("t5_state", 16'(cgs_state), 16'd2);

    // reset while in CS_DATA
    step(1'b1, 1'b1, 10'h0FA);
    check("t6_state", 16'(cgs_state), 16'd0);
    check("t6_sync", 16'(sync_n), 16'd0);
    check("t6_sym_valid", 16'(sym_valid), 16'd0);
    check("t6_offset", 16'(align_offset), 16'd0);

    // randomized phase, symbol mix and gaps
    for (int t = 0; t < 25; t++) begin
      do_reset();
      push_bits($urandom_range(0, 9));
      send_k($urandom_range(2, 7));
      for (int s = 0; s < 30; s++) begin
        if ($urandom_range(0, 2) == 0) send_k(1);
        else push_sym(pick_tab[$urandom_range(0, 5)]);
      end
      flush_words();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
